// File: rtl/pcpi_mat2x2_mac_if.sv
// PCPI handshake bundle for the 2x2 matrix-multiply coprocessor.
// The CPU side drives the master modport and the coprocessor takes the slave modport.
interface pcpi_mat2x2_mac_if;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_ready;
    logic        pcpi_wr;
    logic        pcpi_wait;
    logic [31:0] pcpi_rd;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd
    );
endinterface

// File: rtl/pcpi_mat2x2_mac.sv
// PCPI coprocessor that computes a packed 2x2 u8 matrix product on one shared 8x8 multiplier in 8 MAC cycles.
// The optional saturating MMULS variant is enabled by defining PCPI_MMUL_SAT_EN.
module pcpi_mat2x2_mac (
    input  logic               clk,
    input  logic               resetn,
    pcpi_mat2x2_mac_if.slave   pcpi
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] rs1_r;
    logic [31:0] rs2_r;
    logic [2:0]  k_r;
    logic [16:0] acc_r;
    logic [23:0] part_r;
    logic [31:0] rd_r;
    logic        ready_r;
    logic        wait_r;
`ifdef PCPI_MMUL_SAT_EN
    logic        sat_r;
`endif

    logic        claim_s;
    logic [7:0]  a_op_s;
    logic [7:0]  b_op_s;
    logic [15:0] prod_s;
    logic [16:0] sum_s;
    logic [7:0]  byte_s;
    logic        unused_s;

    function automatic logic claim_f(input logic [31:0] insn);
        logic f3_ok;
`ifdef PCPI_MMUL_SAT_EN
        f3_ok = (insn[14:12] == 3'b000) || (insn[14:12] == 3'b001);
`else
        f3_ok = (insn[14:12] == 3'b000);
`endif
        return (insn[6:0] == 7'b0001011) && (insn[31:25] == 7'b0101000) && f3_ok;
    endfunction

`ifdef PCPI_MMUL_SAT_EN
    function automatic logic [7:0] pack_byte_f(input logic [16:0] acc, input logic sat);
        if (sat && (acc > 17'd255)) begin
            return 8'hFF;
        end else begin
            return acc[7:0];
        end
    endfunction
`else
    function automatic logic [7:0] pack_byte_f(input logic [16:0] acc);
        return acc[7:0];
    endfunction
`endif

    assign claim_s  = pcpi.pcpi_valid && claim_f(pcpi.pcpi_insn);
    assign unused_s = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};

    // Operand select: k[2] picks the result row, k[1] the column, k[0] the inner index.
    always_comb begin
        a_op_s = 8'd0;
        b_op_s = 8'd0;
        case ({k_r[2], k_r[0]})
            2'b00:   a_op_s = rs1_r[7:0];
            2'b01:   a_op_s = rs1_r[15:8];
            2'b10:   a_op_s = rs1_r[23:16];
            2'b11:   a_op_s = rs1_r[31:24];
            default: a_op_s = 8'd0;
        endcase
        case ({k_r[0], k_r[1]})
            2'b00:   b_op_s = rs2_r[7:0];
            2'b01:   b_op_s = rs2_r[15:8];
            2'b10:   b_op_s = rs2_r[23:16];
            2'b11:   b_op_s = rs2_r[31:24];
            default: b_op_s = 8'd0;
        endcase
    end

    assign prod_s = 16'(a_op_s) * 16'(b_op_s);
    assign sum_s  = acc_r + {1'b0, prod_s};
`ifdef PCPI_MMUL_SAT_EN
    assign byte_s = pack_byte_f(sum_s, sat_r);
`else
    assign byte_s = pack_byte_f(sum_s);
`endif

    // Next-state decode; HOLD blocks a still-asserted valid from re-issuing the same instruction.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (claim_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (k_r == 3'd7) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE, ST_HOLD: begin
                if (pcpi.pcpi_valid) begin
                    state_nx_s = ST_HOLD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register and handshake outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            wait_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            wait_r  <= (state_nx_s == ST_RUN);
            ready_r <= (state_nx_s == ST_DONE);
        end
    end

    // Operand latch and MAC datapath; the accumulator restarts at every even k.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rs1_r  <= 32'd0;
            rs2_r  <= 32'd0;
            k_r    <= 3'd0;
            acc_r  <= 17'd0;
            part_r <= 24'd0;
            rd_r   <= 32'd0;
`ifdef PCPI_MMUL_SAT_EN
            sat_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (claim_s) begin
                        rs1_r <= pcpi.pcpi_rs1;
                        rs2_r <= pcpi.pcpi_rs2;
                        k_r   <= 3'd0;
                        acc_r <= 17'd0;
`ifdef PCPI_MMUL_SAT_EN
                        sat_r <= pcpi.pcpi_insn[12];
`endif
                    end
                end
                ST_RUN: begin
                    k_r <= k_r + 3'd1;
                    if (!k_r[0]) begin
                        acc_r <= {1'b0, prod_s};
                    end else begin
                        acc_r <= 17'd0;
                        case (k_r[2:1])
                            2'd0:    part_r[7:0]   <= byte_s;
                            2'd1:    part_r[15:8]  <= byte_s;
                            2'd2:    part_r[23:16] <= byte_s;
                            2'd3:    rd_r          <= {byte_s, part_r};
                            default: acc_r         <= 17'd0;
                        endcase
                    end
                end
                default: acc_r <= acc_r;
            endcase
        end
    end

    assign pcpi.pcpi_ready = ready_r;
    assign pcpi.pcpi_wr    = ready_r;
    assign pcpi.pcpi_wait  = wait_r;
    assign pcpi.pcpi_rd    = rd_r;

endmodule

// File: tb/tb_pcpi_mat2x2_mac.sv
// Self-checking bench for pcpi_mat2x2_mac: vector table plus scoreboard queue of expected results.
module tb_pcpi_mat2x2_mac;

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        bit          claim;
        logic [31:0] exp_rd;
        int          hold;
    } vec_t;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_err;
    logic [31:0] sb_q[$];
    logic [31:0] last_rd;
    vec_t vecs[$];

    pcpi_mat2x2_mac_if bus();

    pcpi_mat2x2_mac dut (
        .clk    (clk),
        .resetn (resetn),
        .pcpi   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Scoreboard: every ready pulse must match the oldest outstanding expected result.
    always @(negedge clk) begin
        if (resetn) begin
            check("wr_equals_ready", {31'd0, bus.pcpi_wr}, {31'd0, bus.pcpi_ready});
            check("wait_ready_exclusive", {31'd0, bus.pcpi_wait & bus.pcpi_ready}, 32'd0);
            if (bus.pcpi_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ready: got rd 0x%08h expected no ready", bus.pcpi_rd);
                end else begin
                    check("scoreboard_rd", bus.pcpi_rd, sb_q.pop_front());
                end
            end
        end
    end

    task automatic run_insn(input string nm, input logic [31:0] insn, input logic [31:0] rs1,
                            input logic [31:0] rs2, input bit claim, input logic [31:0] exp_rd,
                            input int hold);
        int wcnt;
        int rcnt;
        int rdy_at;
        int win;
        wcnt   = 0;
        rcnt   = 0;
        rdy_at = 0;
        win    = (hold > 20) ? hold : 20;
        if (claim) sb_q.push_back(exp_rd);
        bus.pcpi_insn  = insn;
        bus.pcpi_rs1   = rs1;
        bus.pcpi_rs2   = rs2;
        bus.pcpi_valid = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= win; i++) begin
            if (i >= hold) bus.pcpi_valid = 1'b0;
            bus.pcpi_rs1 = $urandom;
            bus.pcpi_rs2 = $urandom;
            if (bus.pcpi_wait) wcnt++;
            if (bus.pcpi_ready) begin
                rcnt++;
                if (rdy_at == 0) rdy_at = i;
            end
            @(negedge clk);
        end
        bus.pcpi_valid = 1'b0;
        if (claim) last_rd = exp_rd;
        check({nm, "_wait_cycles"}, 32'(wcnt), claim ? 32'd8 : 32'd0);
        check({nm, "_ready_count"}, 32'(rcnt), claim ? 32'd1 : 32'd0);
        check({nm, "_latency"}, 32'(rdy_at), claim ? 32'd9 : 32'd0);
        check({nm, "_rd_value"}, bus.pcpi_rd, last_rd);
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        last_rd        = 32'd0;
        resetn         = 1'b0;
        bus.pcpi_valid = 1'b0;
        bus.pcpi_insn  = 32'd0;
        bus.pcpi_rs1   = 32'd0;
        bus.pcpi_rs2   = 32'd0;

        vecs.push_back('{"identity", 32'h5000000B, 32'h01000001, 32'h04030201, 1'b1, 32'h04030201, 1});
        vecs.push_back('{"wrap_max", 32'h5000000B, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h02020202, 1});
        vecs.push_back('{"general", 32'h5000000B, 32'h04030201, 32'h08070605, 1'b1, 32'h322B1613, 1});
        vecs.push_back('{"wrap_512", 32'h5000000B, 32'h10101010, 32'h10101010, 1'b1, 32'h00000000, 1});
        vecs.push_back('{"edge_255", 32'h5000000B, 32'h000F000F, 32'h00110011, 1'b1, 32'h00FF00FF, 1});
`ifdef PCPI_MMUL_SAT_EN
        vecs.push_back('{"sat_max", 32'h5000100B, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1});
        vecs.push_back('{"sat_512", 32'h5000100B, 32'h10101010, 32'h10101010, 1'b1, 32'hFFFFFFFF, 1});
        vecs.push_back('{"sat_edge_255", 32'h5000100B, 32'h000F000F, 32'h00110011, 1'b1, 32'h00FF00FF, 1});
`else
        vecs.push_back('{"mmuls_ignored", 32'h5000100B, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 20});
`endif
        vecs.push_back('{"unclaimed_f7", 32'h0000000B, 32'h01010101, 32'h01010101, 1'b0, 32'h0, 20});
        vecs.push_back('{"unclaimed_op", 32'h50000033, 32'h01010101, 32'h01010101, 1'b0, 32'h0, 20});
        vecs.push_back('{"unclaimed_f3", 32'h5000200B, 32'h01010101, 32'h01010101, 1'b0, 32'h0, 20});

        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, bus.pcpi_ready}, 32'd0);
        check("reset_wr", {31'd0, bus.pcpi_wr}, 32'd0);
        check("reset_wait", {31'd0, bus.pcpi_wait}, 32'd0);
        check("reset_rd", bus.pcpi_rd, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_insn(vecs[i].name, vecs[i].insn, vecs[i].rs1, vecs[i].rs2,
                     vecs[i].claim, vecs[i].exp_rd, vecs[i].hold);
        end

        // Held valid: one result then HOLD; a fresh pulse after release gives a second result.
        run_insn("held_valid", 32'h5000000B, 32'h04030201, 32'h08070605, 1'b1, 32'h322B1613, 30);
        run_insn("repulse", 32'h5000000B, 32'h01000001, 32'h0A0B0C0D, 1'b1, 32'h0A0B0C0D, 1);

        // Reset asserted at edge T+4 aborts the instruction with no ready.
        bus.pcpi_insn  = 32'h5000000B;
        bus.pcpi_rs1   = 32'hFFFFFFFF;
        bus.pcpi_rs2   = 32'hFFFFFFFF;
        bus.pcpi_valid = 1'b1;
        @(negedge clk);
        bus.pcpi_valid = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midreset_ready", {31'd0, bus.pcpi_ready}, 32'd0);
        check("midreset_wr", {31'd0, bus.pcpi_wr}, 32'd0);
        check("midreset_wait", {31'd0, bus.pcpi_wait}, 32'd0);
        check("midreset_rd", bus.pcpi_rd, 32'd0);
        resetn  = 1'b1;
        last_rd = 32'd0;
        repeat (15) @(negedge clk);
        check("midreset_no_result", bus.pcpi_rd, 32'd0);
        run_insn("after_reset", 32'h5000000B, 32'h02020202, 32'h03030303, 1'b1, 32'h0C0C0C0C, 1);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pcpi_mat2x2_mac.md
# pcpi_mat2x2_mac

Sequential PCPI coprocessor that executes a fused 2×2 matrix multiply of packed unsigned 8-bit operands. It sits directly downstream of the nibble-serial instruction assembler in the top module, which supplies the instruction word, the one-cycle `pcpi_valid` pulse and the operands. It returns a packed 32-bit result through the standard PCPI ready/wr/rd handshake. A single 8×8 multiplier is time-shared over 8 MAC cycles.

## Interface
- `clk` input 1 — single clock; all logic is clocked on its rising edge.
- `resetn` input 1 — reset, **synchronous, active-low**.
- `pcpi_valid` input 1 — instruction offered; may be a 1-cycle pulse or held high.
- `pcpi_insn` input 32 — instruction word.
- `pcpi_rs1` input 32 — matrix A, packed `{a11,a10,a01,a00}` with `a00` in [7:0].
- `pcpi_rs2` input 32 — matrix B, packed `{b11,b10,b01,b00}`.
- `pcpi_ready` output 1 — one-cycle result strobe.
- `pcpi_wr` output 1 — equal to `pcpi_ready` (the result is always written).
- `pcpi_wait` output 1 — busy; high while a claimed instruction is in flight.
- `pcpi_rd` output 32 — result, packed `{c11,c10,c01,c00}`.

## Operation
- **Decode (claim):** the block claims an instruction when all three hold:
  - `insn[6:0]=7'b0001011` (custom-0);
  - `insn[31:25]=7'b0101000`;
  - `insn[14:12]` is `3'b000` (MMUL, wrap), or `3'b001` (MMULS, saturate) when enabled.
- Any other instruction is ignored: no wait, no ready, state unchanged.
- **States:**
  - IDLE → RUN on `pcpi_valid` && claim. On that edge the block latches rs1, rs2 and funct3, and clears the accumulator and `k`.
  - RUN: one MAC per edge for k=0..7. At k=7 it goes → DONE.
  - DONE: `pcpi_ready=pcpi_wr=1` for this cycle only. Next state is HOLD if `pcpi_valid` is high, else IDLE.
  - HOLD → IDLE when `pcpi_valid` is low. This guard prevents re-issuing a held `valid`.
- **MAC order**, with the accumulator cleared after each element:
  - k0 `a00*b00`, k1 `+a01*b10` → c00;
  - k2 `a00*b01`, k3 `+a01*b11` → c01;
  - k4 `a10*b00`, k5 `+a11*b10` → c10;
  - k6 `a10*b01`, k7 `+a11*b11` → c11.
- **Arithmetic:**
  - Products are 16 bits. The accumulator is 17 bits (max 2·255² = 130050 = 0x1FC02, no overflow).
  - MMUL stores `acc[7:0]`.
  - MMULS stores `acc>255 ? 8'hFF : acc[7:0]`.
- Operands are latched at acceptance. Changes to `pcpi_valid`, rs1 or rs2 during RUN have no effect.
- `pcpi_rd` is updated only at the edge entering DONE and holds that value until the next result. Partial bytes are built in an internal register.

## Timing
- Reset values: `pcpi_ready=0`, `pcpi_wr=0`, `pcpi_wait=0`, `pcpi_rd=0`. State is IDLE and the accumulator is 0.
- Acceptance edge T:
  - `pcpi_wait` goes high after T and stays high through the cycle after T+7.
  - `pcpi_wait` is low from T+8 onward.
- `pcpi_ready`/`pcpi_wr` are high only in the cycle after edge T+8. This gives a fixed latency of 8 edges from acceptance to result.
- `pcpi_wait` and `pcpi_ready` are never high in the same cycle.
- `pcpi_valid` arriving during RUN, DONE or HOLD is not accepted and is not queued.
- Reset mid-operation (`resetn` low at any edge) aborts at that edge: all outputs return to reset values and no `pcpi_ready` is produced for the aborted instruction.
- A new instruction is accepted no earlier than the edge after DONE; the throughput bound is 1 per 9 cycles.

## Configuration
- `PCPI_MMUL_SAT_EN`:
  - Defined: funct3=`3'b001` (MMULS) is claimed and computed with saturation.
  - Undefined: only funct3=`3'b000` is claimed. An MMULS instruction is ignored like any unclaimed instruction, and the saturation logic is absent.

## Test plan
- **Identity:** insn `0x5000000B`, rs1 `0x01000001`, rs2 `0x04030201` → single `pcpi_ready`/`pcpi_wr` pulse 8 edges after acceptance, `pcpi_rd=0x04030201`, `pcpi_wait` high for exactly 8 cycles.
- **Wrap:** insn `0x5000000B`, rs1=rs2=`0xFFFFFFFF` → `pcpi_rd=0x02020202`.
- **Saturate** (macro defined): insn `0x5000100B`, same operands → `pcpi_rd=0xFFFFFFFF`. With the macro undefined → no wait/ready for 20 cycles, `pcpi_rd` unchanged.
- **Unclaimed:** insn `0x0000000B` and insn `0x50000033`, with `valid` held 20 cycles → `pcpi_wait=pcpi_ready=0` throughout.
- **Held valid:** `pcpi_valid` held high 30 cycles with a claimed insn → exactly one `pcpi_ready` pulse, then HOLD. After `valid` drops and is re-pulsed → a second pulse follows 8 edges later.
- **Reset mid-op:** `resetn` low at T+4 for one cycle → all outputs 0 and no ready. A fresh instruction with rs1 `0x02020202`, rs2 `0x03030303` then yields `pcpi_rd=0x0C0C0C0C`.
